// File: rtl/tbus_mem_responder_pkg.sv
// Shared tbus definitions: operation codes and bus widths used by the memory responder.
package tbus_mem_responder_pkg;

  localparam int TBUS_OPTYPE_RANGE = 2;
  localparam int RESULT_RANGE      = 64;

  localparam logic [TBUS_OPTYPE_RANGE-1:0] TBUS_READ  = 2'b00;
  localparam logic [TBUS_OPTYPE_RANGE-1:0] TBUS_WRITE = 2'b01;

  // Any code other than TBUS_WRITE is serviced as a read.
  function automatic logic optype_is_write(input logic [TBUS_OPTYPE_RANGE-1:0] op);
    return op == TBUS_WRITE;
  endfunction

endpackage

// File: rtl/tbus_sram.sv
// Single-port DEPTHx64 backing store: synchronous read, bit-masked write, array never reset.
module tbus_sram
  import tbus_mem_responder_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                    clock,
  input  logic                    read_en,
  input  logic                    write_en,
  input  logic [AW-1:0]           addr,
  input  logic [RESULT_RANGE-1:0] write_data,
  input  logic [RESULT_RANGE-1:0] write_mask,
  output logic [RESULT_RANGE-1:0] read_data
);

  logic [RESULT_RANGE-1:0] mem [DEPTH];

  // Output register only moves on a read, so it holds between reads.
  always_ff @(posedge clock) begin
    if (write_en) begin
      mem[addr] <= (mem[addr] & ~write_mask) | (write_data & write_mask);
    end
    if (read_en) begin
      read_data <= mem[addr];
    end
  end

endmodule

// File: rtl/tbus_mem_responder.sv
// tbus responder with fixed-latency access to a local SRAM.
// Optional TBUS_RESP_FLUSH_EN lets the requester flush abort an outstanding read.
module tbus_mem_responder
  import tbus_mem_responder_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         tbus_index_valid,
  output logic                         tbus_index_ready,
  input  logic [63:0]                  tbus_index,
  input  logic [RESULT_RANGE-1:0]      tbus_write_data,
  input  logic [RESULT_RANGE-1:0]      tbus_write_mask,
  input  logic [TBUS_OPTYPE_RANGE-1:0] tbus_operation_type,
  output logic [RESULT_RANGE-1:0]      tbus_read_data,
  output logic                         tbus_operation_done,
  input  logic                         tbus_flush_valid,
  output logic [1:0]                   fsm_state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Handshake: a request transfers on a rising edge where valid and ready are both high;
  // ready is a function of state (and flush) only, never of valid.

  state_t                  state, next_state;
  logic [3:0]              cnt, next_cnt;
  logic [AW-1:0]           word_q;
  logic                    write_q;
  logic [RESULT_RANGE-1:0] wdata_q, mask_q, held_q;
  logic                    ready, accept, flush_kill;
  logic                    sram_re, sram_we, show_new;
  logic [AW-1:0]           sram_addr;
  logic [RESULT_RANGE-1:0] sram_rdata;
  logic [AW-1:0]           in_word;
  logic                    index_unused;

  assign in_word      = tbus_index[AW+2:3];
  assign index_unused = ^{tbus_index[63:AW+3], tbus_index[2:0]};

`ifdef TBUS_RESP_FLUSH_EN
  assign flush_kill = tbus_flush_valid & ~write_q & (state != IDLE);
`else
  logic flush_unused;
  assign flush_unused = tbus_flush_valid;
  assign flush_kill   = 1'b0;
`endif

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    ready      = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
`ifdef TBUS_RESP_FLUSH_EN
        ready = ~tbus_flush_valid;
`else
        ready = 1'b1;
`endif
        accept = tbus_index_valid & ready;
        if (accept) begin
          next_cnt   = CNT_LOAD;
          next_state = (LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (flush_kill) begin
          next_state = IDLE;
          next_cnt   = 4'd0;
        end else begin
          next_cnt = cnt - 4'd1;
          if (cnt <= 4'd1) next_state = RESP;
        end
      end
      RESP: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
        next_cnt   = 4'd0;
      end
    endcase
  end

  // Read is launched one cycle ahead so the SRAM output lands in the RESP cycle.
  always_comb begin
    sram_addr = (state == IDLE) ? in_word : word_q;
    sram_re   = 1'b0;
    if (next_state == RESP) begin
      sram_re = (state == IDLE) ? ~optype_is_write(tbus_operation_type) : ~write_q;
    end
  end

  assign sram_we             = (state == RESP) & write_q & reset_n;
  assign tbus_operation_done = (state == RESP) & ~flush_kill & reset_n;
  assign show_new            = tbus_operation_done & ~write_q;
  assign tbus_read_data      = show_new ? sram_rdata : held_q;
  assign tbus_index_ready    = ready;
  assign fsm_state           = state;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      word_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      mask_q  <= '0;
      held_q  <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      if (accept) begin
        word_q  <= in_word;
        write_q <= optype_is_write(tbus_operation_type);
        wdata_q <= tbus_write_data;
        mask_q  <= tbus_write_mask;
      end
      if (show_new) held_q <= sram_rdata;
    end
  end

  tbus_sram #(.DEPTH(DEPTH)) u_sram (
    .clock      (clock),
    .read_en    (sram_re),
    .write_en   (sram_we),
    .addr       (sram_addr),
    .write_data (wdata_q),
    .write_mask (mask_q),
    .read_data  (sram_rdata)
  );

endmodule

// File: tb/tb_tbus_mem_responder.sv
// Bench for tbus_mem_responder: directed scenarios plus randomized traffic against a word-array model.
module tb_tbus_mem_responder;

  localparam int DEPTH = 1024;
  localparam int L     = 2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        tbus_index_valid = 1'b0;
  logic        tbus_index_ready;
  logic [63:0] tbus_index = '0;
  logic [63:0] tbus_write_data = '0;
  logic [63:0] tbus_write_mask = '0;
  logic [1:0]  tbus_operation_type = 2'b00;
  logic [63:0] tbus_read_data;
  logic        tbus_operation_done;
  logic        tbus_flush_valid = 1'b0;
  logic [1:0]  fsm_state;

  int total = 0;
  int bad   = 0;

  logic [63:0] model_mem [int];
  logic [63:0] last_read = '0;
  logic [63:0] exp_q[$];

  tbus_mem_responder #(.DEPTH(DEPTH), .LATENCY(L)) dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .tbus_index_valid    (tbus_index_valid),
    .tbus_index_ready    (tbus_index_ready),
    .tbus_index          (tbus_index),
    .tbus_write_data     (tbus_write_data),
    .tbus_write_mask     (tbus_write_mask),
    .tbus_operation_type (tbus_operation_type),
    .tbus_read_data      (tbus_read_data),
    .tbus_operation_done (tbus_operation_done),
    .tbus_flush_valid    (tbus_flush_valid),
    .fsm_state           (fsm_state)
  );

  always #5 clock = ~clock;

  function automatic int word_of(input logic [63:0] addr);
    return int'((addr / 64'd8) % 64'(DEPTH));
  endfunction

  function automatic void model_access(input bit wr, input logic [63:0] addr,
                                       input logic [63:0] wd, input logic [63:0] mk);
    int w;
    w = word_of(addr);
    if (wr) begin
      model_mem[w] = (model_mem[w] & ~mk) | (wd & mk);
    end else begin
      last_read = model_mem[w];
    end
  endfunction

  // Presents one request at a negedge, drops valid after the accepting edge, then records
  // done/ready at negedges k=0..L+1 (k=0 is the acceptance cycle) and read data at k=L.
  task automatic run_op(input bit wr, input logic [63:0] addr, input logic [63:0] wd,
                        input logic [63:0] mk, output logic [15:0] done_seq,
                        output logic [15:0] rdy_seq, output logic [63:0] rd);
    done_seq = '0;
    rdy_seq  = '0;
    rd       = '0;
    @(negedge clock);
    tbus_index_valid    = 1'b1;
    tbus_index          = addr;
    tbus_write_data     = wd;
    tbus_write_mask     = mk;
    tbus_operation_type = wr ? 2'b01 : 2'b00;
    #1;
    done_seq[0] = tbus_operation_done;
    rdy_seq[0]  = tbus_index_ready;
    @(posedge clock);
    #1 tbus_index_valid = 1'b0;
    for (int k = 1; k <= L + 1; k++) begin
      @(negedge clock);
      done_seq[k] = tbus_operation_done;
      rdy_seq[k]  = tbus_index_ready;
      if (k == L) rd = tbus_read_data;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    total++;
    if (tbus_index_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready got=%b want=1", tbus_index_ready);
    end
    total++;
    if (tbus_operation_done !== 1'b0) begin
      bad++; $display("FAIL reset_done got=%b want=0", tbus_operation_done);
    end
    total++;
    if (tbus_read_data !== 64'h0) begin
      bad++; $display("FAIL reset_read_data got=%h want=0", tbus_read_data);
    end
  endtask

  task automatic test_write_read;
    logic [15:0] ds, rs;
    logic [63:0] rd;
    logic [15:0] exp_done, exp_rdy;
    exp_done = 16'(1) << L;
    exp_rdy  = 16'(1) | (16'(1) << (L + 1));
    run_op(1'b1, 64'h40, 64'h1122334455667788, '1, ds, rs, rd);
    model_access(1'b1, 64'h40, 64'h1122334455667788, '1);
    total++;
    if (ds !== exp_done) begin
      bad++; $display("FAIL write_done_timing got=%b want=%b", ds, exp_done);
    end
    total++;
    if (rs !== exp_rdy) begin
      bad++; $display("FAIL write_ready_timing got=%b want=%b", rs, exp_rdy);
    end
    run_op(1'b0, 64'h40, '0, '0, ds, rs, rd);
    model_access(1'b0, 64'h40, '0, '0);
    total++;
    if (ds !== exp_done) begin
      bad++; $display("FAIL read_done_timing got=%b want=%b", ds, exp_done);
    end
    total++;
    if (rd !== 64'h1122334455667788) begin
      bad++; $display("FAIL read_full got=%h want=1122334455667788", rd);
    end
  endtask

  task automatic test_masked_write;
    logic [15:0] ds, rs;
    logic [63:0] rd;
    run_op(1'b1, 64'h40, 64'hAB << 16, 64'hFF << 16, ds, rs, rd);
    model_access(1'b1, 64'h40, 64'hAB << 16, 64'hFF << 16);
    run_op(1'b0, 64'h40, '0, '0, ds, rs, rd);
    model_access(1'b0, 64'h40, '0, '0);
    total++;
    if (rd !== 64'h1122334455AB7788) begin
      bad++; $display("FAIL masked_write got=%h want=1122334455ab7788", rd);
    end
    // All-zero mask completes but leaves the word alone.
    run_op(1'b1, 64'h40, 64'hFFFF_FFFF_FFFF_FFFF, '0, ds, rs, rd);
    total++;
    if (ds[L] !== 1'b1) begin
      bad++; $display("FAIL zero_mask_done got=%b want=1", ds[L]);
    end
    run_op(1'b0, 64'h40, '0, '0, ds, rs, rd);
    total++;
    if (rd !== 64'h1122334455AB7788) begin
      bad++; $display("FAIL zero_mask_data got=%h want=1122334455ab7788", rd);
    end
  endtask

  task automatic test_alias;
    logic [15:0] ds, rs;
    logic [63:0] rd;
    run_op(1'b1, 64'(DEPTH) * 8 + 64'h8, 64'h5A, '1, ds, rs, rd);
    model_access(1'b1, 64'(DEPTH) * 8 + 64'h8, 64'h5A, '1);
    run_op(1'b0, 64'h8, '0, '0, ds, rs, rd);
    model_access(1'b0, 64'h8, '0, '0);
    total++;
    if (rd !== 64'h5A) begin
      bad++; $display("FAIL alias got=%h want=5a", rd);
    end
  endtask

  // Valid held high across two reads: second accepted at T+L+1, done at T+2L+1.
  task automatic test_back_to_back;
    logic [2*L+2:0] rdy_seen, done_seen, exp_rdy, exp_done;
    logic [63:0] rd1, rd2;
    rdy_seen = '0; done_seen = '0; rd1 = '0; rd2 = '0;
    exp_rdy  = '0; exp_done = '0;
    exp_rdy[L+1]    = 1'b1;
    exp_rdy[2*L+2]  = 1'b1;
    exp_done[L]     = 1'b1;
    exp_done[2*L+1] = 1'b1;
    @(negedge clock);
    tbus_index_valid    = 1'b1;
    tbus_index          = 64'h40;
    tbus_operation_type = 2'b00;
    @(posedge clock);
    #1 tbus_index = 64'h8;
    for (int k = 1; k <= 2 * L + 2; k++) begin
      @(negedge clock);
      rdy_seen[k]  = tbus_index_ready;
      done_seen[k] = tbus_operation_done;
      if (k == L) rd1 = tbus_read_data;
      if (k == 2 * L + 1) rd2 = tbus_read_data;
      if (k == L + 2) tbus_index_valid = 1'b0;
    end
    total++;
    if (rdy_seen[2*L+2:1] !== exp_rdy[2*L+2:1]) begin
      bad++; $display("FAIL b2b_ready got=%b want=%b", rdy_seen[2*L+2:1], exp_rdy[2*L+2:1]);
    end
    total++;
    if (done_seen[2*L+2:1] !== exp_done[2*L+2:1]) begin
      bad++; $display("FAIL b2b_done got=%b want=%b", done_seen[2*L+2:1], exp_done[2*L+2:1]);
    end
    total++;
    if (rd1 !== model_mem[word_of(64'h40)] || rd2 !== model_mem[word_of(64'h8)]) begin
      bad++; $display("FAIL b2b_data got=%h/%h want=%h/%h", rd1, rd2,
                      model_mem[word_of(64'h40)], model_mem[word_of(64'h8)]);
    end
    last_read = model_mem[word_of(64'h8)];
  endtask

  task automatic test_flush;
    logic [15:0] ds, rs;
    logic [63:0] rd, prev;
    logic        d1, d2, r2;
    prev = last_read;
    @(negedge clock);
    tbus_index_valid    = 1'b1;
    tbus_index          = 64'h40;
    tbus_operation_type = 2'b00;
    @(posedge clock);
    #1 tbus_index_valid = 1'b0;
    @(negedge clock);
    tbus_flush_valid = 1'b1;
    #1 d1 = tbus_operation_done;
    @(negedge clock);
    tbus_flush_valid = 1'b0;
    #1;
    d2 = tbus_operation_done;
    r2 = tbus_index_ready;
    rd = tbus_read_data;
`ifdef TBUS_RESP_FLUSH_EN
    total++;
    if (d1 !== 1'b0 || d2 !== 1'b0) begin
      bad++; $display("FAIL flush_read_done got=%b%b want=00", d1, d2);
    end
    total++;
    if (rd !== prev || r2 !== 1'b1) begin
      bad++; $display("FAIL flush_read_hold data=%h ready=%b want=%h/1", rd, r2, prev);
    end
`else
    model_access(1'b0, 64'h40, '0, '0);
    total++;
    if (d1 !== 1'b0 || d2 !== 1'b1) begin
      bad++; $display("FAIL noflush_read_done got=%b%b want=01", d1, d2);
    end
    total++;
    if (rd !== last_read) begin
      bad++; $display("FAIL noflush_read_data got=%h want=%h (prev %h)", rd, last_read, prev);
    end
`endif
    // A write under the same flush pattern always completes.
    @(negedge clock);
    tbus_index_valid    = 1'b1;
    tbus_index          = 64'h100;
    tbus_write_data     = 64'hFEED_0000_BEEF_0001;
    tbus_write_mask     = '1;
    tbus_operation_type = 2'b01;
    @(posedge clock);
    #1 tbus_index_valid = 1'b0;
    @(negedge clock);
    tbus_flush_valid = 1'b1;
    @(negedge clock);
    tbus_flush_valid = 1'b0;
    #1 d2 = tbus_operation_done;
    model_access(1'b1, 64'h100, 64'hFEED_0000_BEEF_0001, '1);
    total++;
    if (d2 !== 1'b1) begin
      bad++; $display("FAIL flush_write_done got=%b want=1", d2);
    end
    run_op(1'b0, 64'h100, '0, '0, ds, rs, rd);
    model_access(1'b0, 64'h100, '0, '0);
    total++;
    if (rd !== 64'hFEED_0000_BEEF_0001) begin
      bad++; $display("FAIL flush_write_data got=%h want=feed0000beef0001", rd);
    end
  endtask

  task automatic test_reset_mid_op;
    logic [15:0] ds, rs;
    logic [63:0] rd;
    logic        d1, d2, r3;
    run_op(1'b1, 64'h28, 64'hCAFE, '1, ds, rs, rd);
    model_access(1'b1, 64'h28, 64'hCAFE, '1);
    @(negedge clock);
    tbus_index_valid    = 1'b1;
    tbus_index          = 64'h28;
    tbus_write_data     = 64'hDEAD;
    tbus_write_mask     = '1;
    tbus_operation_type = 2'b01;
    @(posedge clock);
    #1 tbus_index_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b0;
    #1 d1 = tbus_operation_done;
    @(negedge clock);
    d2 = tbus_operation_done;
    reset_n = 1'b1;
    @(negedge clock);
    r3 = tbus_index_ready;
    total++;
    if (d1 !== 1'b0 || d2 !== 1'b0 || tbus_operation_done !== 1'b0) begin
      bad++; $display("FAIL reset_mid_done got=%b%b%b want=000", d1, d2, tbus_operation_done);
    end
    total++;
    if (r3 !== 1'b1 || tbus_read_data !== 64'h0) begin
      bad++; $display("FAIL reset_mid_state ready=%b data=%h want=1/0", r3, tbus_read_data);
    end
    last_read = '0;
    run_op(1'b0, 64'h28, '0, '0, ds, rs, rd);
    model_access(1'b0, 64'h28, '0, '0);
    total++;
    if (rd !== 64'hCAFE) begin
      bad++; $display("FAIL reset_mid_mem got=%h want=cafe", rd);
    end
  endtask

  task automatic test_random;
    logic [15:0] ds, rs;
    logic [63:0] rd, addr, wd, mk, want;
    bit wr;
    int w;
    for (int i = 0; i < 16; i++) begin
      wd = {$urandom, $urandom};
      run_op(1'b1, 64'(i) * 8, wd, '1, ds, rs, rd);
      model_access(1'b1, 64'(i) * 8, wd, '1);
    end
    for (int i = 0; i < 40; i++) begin
      w    = $urandom_range(0, 15);
      addr = 64'($urandom_range(0, 1000)) * 64'(DEPTH) * 8 + 64'(w) * 8 + 64'($urandom_range(0, 7));
      wr   = $urandom_range(0, 1) == 1;
      wd   = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       mk = '0;
        1:       mk = '1;
        default: mk = {$urandom, $urandom};
      endcase
      if (!wr) exp_q.push_back(model_mem[w]);
      tbus_operation_type = 2'(wr ? 1 : ($urandom_range(0, 1) == 1 ? 3 : 0));
      run_op(wr, addr, wd, mk, ds, rs, rd);
      model_access(wr, addr, wd, mk);
      total++;
      if (ds !== (16'(1) << L)) begin
        bad++; $display("FAIL rand_done i=%0d got=%b want=%b", i, ds, 16'(1) << L);
      end
      if (!wr) begin
        want = exp_q.pop_front();
        total++;
        if (rd !== want) begin
          bad++; $display("FAIL rand_read i=%0d addr=%h got=%h want=%h", i, addr, rd, want);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_masked_write();
    test_back_to_back();
    test_alias();
    test_flush();
    test_reset_mid_op();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
